uart_tx_buffered: RTL



---
 rtl/uart_tx_buffered_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_tx_buffered.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
// Provides the frame FSM states, the data width and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DATA_BITS       = 8;
  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_BAUD        = 9600;

  // Integer division; the result must be at least 2 for the bit counter to make sense.
  function automatic int bps_div(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte queue with a show-ahead head (dout always presents the oldest entry).
// The caller never pushes while full or pops while empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately left unreset; the level and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO queue, LSB-first serialiser.
// The line register lags the FSM by one clock so every bit lasts exactly BPS_DIV clocks.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD,
  parameter int BPS_DIV     = bps_div(CLK_FREQ_HZ, BAUD),
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(BPS_DIV);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  uart_state_e           state, state_d;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [IDX_W-1:0]      bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_reg, shift_d;
  logic                  line_d;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_BITS-1:0]  fifo_dout;
  logic                  fifo_nonempty;
  logic                  bit_end;

  assign tx_ready      = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign fifo_push     = tx_valid && tx_ready;
  assign fifo_nonempty = (fifo_level != '0);
  assign bit_end       = (bit_cnt == CNT_MAX);
  assign tx_busy       = (state != IDLE) || fifo_nonempty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      bit_idx   <= bit_idx_d;
      shift_reg <= shift_d;
      uart_tx   <= line_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift_reg;
    fifo_pop  = 1'b0;
    line_d    = 1'b1;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        line_d    = 1'b0;
        bit_cnt_d = bit_cnt + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        line_d    = shift_reg[0];
        bit_cnt_d = bit_cnt + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_reg[DATA_BITS-1:1]};
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == IDX_MAX) state_d = STOP;
        end
      end
      STOP: begin
        bit_cnt_d = bit_cnt + 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (fifo_nonempty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
